// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter: FSM encoding,
// port-select codes and the data value returned on a watchdog timeout.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERV_DM = 2'd1,
    SERV_IF = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam logic [31:0] TIMEOUT_RDATA = 32'd0;

  function automatic logic is_serving(input state_t s);
    return (s == SERV_DM) || (s == SERV_IF);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Transaction watchdog: counts cycles while enabled and flags the cycle whose
// increment brings the count to TIMEOUT. TIMEOUT of 0 never expires.
module mem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      assign expired = enable && (count_reg == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// running one multi-cycle transaction at a time and returning per-port stalls.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_stall,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  mem_err,
  output logic [31:0]           conflict_cnt
);

  state_t                state_reg, state_next;
  logic                  mem_req_reg, mem_req_next;
  logic                  mem_we_reg, mem_we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_WIDTH-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_WIDTH-1:0] dm_rdata_reg, dm_rdata_next;
  logic                  if_done_reg, if_done_next;
  logic                  dm_done_reg, dm_done_next;
  logic                  mem_err_reg, mem_err_next;
  logic [31:0]           conflict_reg, conflict_next;

  logic dm_any;
  logic dm_elig;
  logic if_elig;
  logic grant_port;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  assign dm_any  = dm_rd | dm_wr;
  assign dm_elig = dm_any & ~dm_done_reg;
  assign if_elig = if_req & ~if_done_reg;
  // The MEM-stage access belongs to the older instruction, so it wins ties.
  assign grant_port = dm_elig ? PORT_DM : PORT_IF;

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      if_done_reg   <= 1'b0;
      dm_done_reg   <= 1'b0;
      mem_err_reg   <= 1'b0;
      conflict_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
      if_done_reg   <= if_done_next;
      dm_done_reg   <= dm_done_next;
      mem_err_reg   <= mem_err_next;
      conflict_reg  <= conflict_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;
    if_done_next   = 1'b0;
    dm_done_next   = 1'b0;
    mem_err_next   = mem_err_reg;
    conflict_next  = conflict_reg;
    wd_enable      = is_serving(state_reg);
    wd_clear       = ~is_serving(state_reg);

    case (state_reg)
      IDLE: begin
        if (dm_elig && if_elig) begin
          conflict_next = conflict_reg + 32'd1;
        end
        if (dm_elig || if_elig) begin
          mem_req_next = 1'b1;
          if (grant_port == PORT_DM) begin
            state_next     = SERV_DM;
            mem_we_next    = dm_wr;
            mem_addr_next  = dm_addr;
            mem_wdata_next = dm_wdata;
          end else begin
            state_next     = SERV_IF;
            mem_we_next    = 1'b0;
            mem_addr_next  = if_addr;
            mem_wdata_next = '0;
          end
        end
      end

      SERV_DM, SERV_IF: begin
        if (mem_ack) begin
          wd_clear     = 1'b1;
          state_next   = IDLE;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          if (state_reg == SERV_DM) begin
            dm_done_next = 1'b1;
            if (!mem_we_reg) begin
              dm_rdata_next = mem_rdata;
            end
          end else begin
            if_done_next  = 1'b1;
            if_rdata_next = mem_rdata;
          end
        end else if (wd_expired) begin
          // Release the stalled port with a defined value rather than hang the pipeline.
          state_next   = IDLE;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          mem_err_next = 1'b1;
          if (state_reg == SERV_DM) begin
            dm_done_next  = 1'b1;
            dm_rdata_next = DATA_WIDTH'(TIMEOUT_RDATA);
          end else begin
            if_done_next  = 1'b1;
            if_rdata_next = DATA_WIDTH'(TIMEOUT_RDATA);
          end
        end
      end

      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
        mem_we_next  = 1'b0;
      end
    endcase
  end

  assign if_stall     = if_req & ~if_done_reg;
  assign dm_stall     = dm_any & ~dm_done_reg;
  assign if_rdata     = if_rdata_reg;
  assign dm_rdata     = dm_rdata_reg;
  assign mem_req      = mem_req_reg;
  assign mem_we       = mem_we_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign mem_err      = mem_err_reg;
  assign conflict_cnt = conflict_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable backing memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] conflict_cnt;

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 3;
  logic force_ack = 1'b0;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_stall    (if_stall),
    .dm_rd       (dm_rd),
    .dm_wr       (dm_wr),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_stall    (dm_stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .mem_err     (mem_err),
    .conflict_cnt(conflict_cnt)
  );

  // Backing memory: acks on the mem_lat-th cycle of mem_req; mem_lat=0 never acks.
  initial begin
    int age;
    age = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h20080005;
    mem[1]  = 32'h8C010100;
    mem[64] = 32'h00001234;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
      end else if (mem_req && mem_lat != 0) begin
        age = age + 1;
        if (age == mem_lat) begin
          mem_ack = 1'b1;
          age = 0;
          if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
          else        mem_rdata = mem[mem_addr[9:2]];
        end
      end else begin
        age = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    int stall_n;
    int req_n;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    tick(); tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_conflict", conflict_cnt, 32'd0);
    rst = 1'b0;
    tick();

    // IF-only fetch with latency 3
    if_req = 1'b1; if_addr = 32'h0; #1;
    stall_n = 0; req_n = 0;
    for (int i = 0; i < 20 && if_stall; i++) begin
      stall_n++;
      if (mem_req) req_n++;
      tick();
    end
    check("if_stall_cycles", 32'(stall_n), 32'd4);
    check("if_mem_req_cycles", 32'(req_n), 32'd3);
    check("if_rdata", if_rdata, 32'h20080005);
    // Request held one cycle past done must not be re-granted
    tick();
    if_req = 1'b0;
    check("held_no_regrant", 32'(mem_req), 32'd0);
    tick();
    check("held_no_regrant2", 32'(mem_req), 32'd0);
    $display("txn if_fetch addr=0x0 stall=%0d req=%0d rdata=0x%08h", stall_n, req_n, if_rdata);

    // Simultaneous DM read and IF fetch
    dm_rd = 1'b1; dm_addr = 32'h100; if_req = 1'b1; if_addr = 32'h4;
    tick();
    check("conf_dm_first_addr", mem_addr, 32'h100);
    check("conf_dm_we", 32'(mem_we), 32'd0);
    for (int i = 0; i < 20 && dm_stall; i++) tick();
    check("conf_dm_released", 32'(dm_stall), 32'd0);
    check("conf_dm_rdata", dm_rdata, 32'h1234);
    check("conf_if_still_stalled", 32'(if_stall), 32'd1);
    check("conf_cnt", conflict_cnt, 32'd1);
    dm_rd = 1'b0;
    tick();
    check("conf_if_granted_req", 32'(mem_req), 32'd1);
    check("conf_if_granted_addr", mem_addr, 32'h4);
    for (int i = 0; i < 20 && if_stall; i++) tick();
    check("conf_if_released", 32'(if_stall), 32'd0);
    check("conf_if_rdata", if_rdata, 32'h8C010100);
    if_req = 1'b0;
    tick();
    check("conf_cnt_after", conflict_cnt, 32'd1);
    $display("txn conflict dm=0x%08h if=0x%08h cnt=%0d", dm_rdata, if_rdata, conflict_cnt);

    // Store then load of the same address
    dm_wr = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hCAFEF00D;
    tick();
    check("st_mem_req", 32'(mem_req), 32'd1);
    check("st_mem_we", 32'(mem_we), 32'd1);
    check("st_mem_wdata", mem_wdata, 32'hCAFEF00D);
    for (int i = 0; i < 20 && dm_stall; i++) tick();
    check("st_released", 32'(dm_stall), 32'd0);
    check("st_dm_rdata_kept", dm_rdata, 32'h1234);
    check("st_we_dropped", 32'(mem_we), 32'd0);
    check("st_mem_written", mem[128], 32'hCAFEF00D);
    dm_wr = 1'b0;
    tick();
    dm_rd = 1'b1;
    tick();
    check("ld_mem_we", 32'(mem_we), 32'd0);
    check("ld_mem_req", 32'(mem_req), 32'd1);
    for (int i = 0; i < 20 && dm_stall; i++) tick();
    check("ld_dm_rdata", dm_rdata, 32'hCAFEF00D);
    dm_rd = 1'b0;
    tick();
    $display("txn store_load addr=0x200 rdata=0x%08h", dm_rdata);

    // Watchdog: memory never acks, TIMEOUT=8
    mem_lat = 0;
    dm_rd = 1'b1; dm_addr = 32'h300; #1;
    req_n = 0;
    for (int i = 0; i < 40 && dm_stall; i++) begin
      if (mem_req) req_n++;
      tick();
    end
    check("wd_serv_cycles", 32'(req_n), 32'd8);
    check("wd_mem_err", 32'(mem_err), 32'd1);
    check("wd_dm_rdata", dm_rdata, 32'h0);
    check("wd_mem_req", 32'(mem_req), 32'd0);
    dm_rd = 1'b0;
    tick(); tick(); tick();
    check("wd_err_sticky", 32'(mem_err), 32'd1);
    $display("txn watchdog serv=%0d err=%0d rdata=0x%08h", req_n, mem_err, dm_rdata);

    // Reset in the second SERV_IF cycle, then a stray ack
    if_req = 1'b1; if_addr = 32'h0;
    tick();
    check("rm_serving", 32'(mem_req), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("rm_mem_req", 32'(mem_req), 32'd0);
    check("rm_if_stall", 32'(if_stall), 32'd1);
    check("rm_conflict", conflict_cnt, 32'd0);
    check("rm_mem_err", 32'(mem_err), 32'd0);
    check("rm_if_rdata", if_rdata, 32'h0);
    rst = 1'b0; if_req = 1'b0; force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("stray_mem_req", 32'(mem_req), 32'd0);
    check("stray_if_rdata", if_rdata, 32'h0);
    check("stray_dm_rdata", dm_rdata, 32'h0);
    check("stray_if_stall", 32'(if_stall), 32'd0);
    tick();
    check("stray_idle", 32'(mem_req), 32'd0);
    $display("txn reset_mid req=%0d err=%0d", mem_req, mem_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port (IF) and its data-access port (MEM stage).
- Replaces the separate zero-latency instruction and data memories.
- Arbitrates, sequences one multi-cycle memory transaction at a time, and returns per-port stall signals; the pipeline ORs these into its global hazard stall.
- Includes a transaction watchdog and a conflict counter.

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 32, byte address width
TIMEOUT, 255, maximum cycles to wait for mem_ack; 0 disables the watchdog

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
if_req  input  1  IF stage requests an instruction fetch
if_addr  input  ADDR_WIDTH  fetch address (PC)
if_rdata  output  DATA_WIDTH  fetched instruction, registered
if_stall  output  1  IF must hold PC and request
dm_rd  input  1  MEM stage load
dm_wr  input  1  MEM stage store
dm_addr  input  ADDR_WIDTH  data address
dm_wdata  input  DATA_WIDTH  store data
dm_rdata  output  DATA_WIDTH  load data, registered
dm_stall  output  1  MEM stage must hold
mem_req  output  1  backing-memory request, held until ack
mem_we  output  1  write enable, valid with mem_req
mem_addr  output  ADDR_WIDTH  latched address
mem_wdata  output  DATA_WIDTH  latched store data
mem_rdata  input  DATA_WIDTH  read data, valid with mem_ack
mem_ack  input  1  one-cycle completion pulse, earliest the cycle after mem_req rises
mem_err  output  1  sticky watchdog error
conflict_cnt  output  32  count of cycles in which both ports requested in IDLE

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_rdata=0, dm_rdata=0; done flags=0; mem_err=0; conflict_cnt=0; watchdog=0.
  - Reset mid-transaction abandons it. A later stray mem_ack is ignored in IDLE.
- FSM states: IDLE, SERV_DM, SERV_IF.
- IDLE:
  - A request is eligible if asserted and its port's done flag is 0.
  - dm_rd|dm_wr has fixed priority over if_req, because the MEM-stage instruction is older.
  - On grant, latch addr/wdata/we into the mem_* registers and set mem_req=1 from the next cycle.
  - Next state is SERV_DM or SERV_IF.
  - If both ports are eligible, conflict_cnt increments (wraps at 2^32).
- SERV_x:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - The watchdog counts up each cycle.
  - On mem_ack:
    - Reads: capture mem_rdata into x_rdata. Stores: dm_rdata is unchanged.
    - Set x_done=1 and mem_req=0; go to IDLE; clear the watchdog.
  - If TIMEOUT≠0 and the watchdog reaches TIMEOUT without ack:
    - Set mem_err=1 (sticky until rst); x_rdata=0; x_done=1; go to IDLE.
- Done flags:
  - Set for exactly one cycle, the cycle after ack; cleared unconditionally the following cycle.
  - During that cycle the pipeline advances, and the same still-asserted request must not be re-granted.
- Stalls (combinational from registered state):
  - if_stall = if_req & ~if_done.
  - dm_stall = (dm_rd|dm_wr) & ~dm_done.
  - The IDLE grant cycle itself stalls, so minimum access latency is ack latency + 1 cycles.
- Back-to-back:
  - A new eligible request can be granted in the cycle its port's done is high only if it is the other port.
  - The same port waits one cycle.
  - A pending IF is granted in the same IDLE cycle where dm_done=1.
- dm_rd and dm_wr together: treated as a store (mem_we=1).
- Requesters hold address, data and controls stable while stalled. Changes during SERV_x are ignored because values are latched.
- No preemption: an in-flight IF fetch completes even if a data request arrives.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, SERV_DM=2'd1, SERV_IF=2'd2).
  - The 32'd0 timeout read value.
  - The port-select constants PORT_IF and PORT_DM.
- One natural sub-module: mem_watchdog, a TIMEOUT-parameterised counter with clear/enable inputs and an expired output, instantiated once.

Test Plan:
- IF-only fetch, bench memory latency 3, if_addr=0x0, mem holds 0x20080005:
  - if_stall high for 4 cycles.
  - if_rdata=0x20080005 when if_stall drops.
  - mem_req high for exactly 3 cycles.
- Simultaneous dm_rd (addr 0x100, data 0x1234) and if_req (addr 0x4):
  - DM is served first and dm_rdata=0x1234.
  - IF is granted in the dm_done cycle.
  - conflict_cnt=1.
- Store dm_wr addr 0x200, wdata 0xCAFEF00D, then dm_rd 0x200:
  - mem_we=1 only during the store.
  - dm_rdata=0xCAFEF00D.
  - dm_rdata unchanged after the store.
- Held request across done: keep if_req=1 with the same address for 1 cycle after done → no second mem_req for that fetch.
- Watchdog, TIMEOUT=8, memory never acks:
  - After 8 SERV cycles: mem_err=1, dm_rdata=0, dm_stall released.
  - mem_err stays high until rst.
- Reset mid-transaction:
  - Assert rst in SERV_IF cycle 2 → next cycle mem_req=0, if_stall=if_req, all counters 0.
  - A late mem_ack is ignored.
